maze_loader: RTL

// - Writer side of the rat-maze map memory: takes maze rows from a valid/ready stream and

---
 rtl/maze_pkg.sv | 27 ++
 rtl/maze_row_shifter.sv | 46 ++++
 rtl/maze_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
// Shared definitions for the rat-maze map loader.
//   - loader_state_t : loader FSM states (CHECK is reachable only when the
//                      MAZE_CHECK_EN macro is defined)
//   - MAZE_N         : default maze dimension (N x N cells, power of 2)
//   - COORD_W        : coordinate width for MAZE_N
//   - WALL           : cell value that marks a wall in the map memory
// -----------------------------------------------------------------------------
package maze_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        ACCEPT,
        START,
        RELEASE,
        SOLVE,
        CHECK
    } loader_state_t;

    localparam int MAZE_N  = 16;
    localparam int COORD_W = $clog2(MAZE_N);

    localparam logic WALL = 1'b1;

endpackage

// File: rtl/maze_row_shifter.sv
// -----------------------------------------------------------------------------
// maze_row_shifter
// Holds the maze row currently being written and presents one cell of it.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous reset, active-low
//   load    : capture row_in this cycle (row stream handshake)
//   row_in  : N-bit row, bit x = cell x of the row
//   sel_x   : column whose cell is presented on bit_out
//   bit_out : row_q[sel_x], the cell value to write to memory
// -----------------------------------------------------------------------------
module maze_row_shifter
    import maze_pkg::*;
#(
    parameter int N       = MAZE_N,
    parameter int COORD_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [N-1:0]       row_in,
    input  logic [COORD_W-1:0] sel_x,
    output logic               bit_out
);

    logic [N-1:0] row_q;
    logic [N-1:0] row_d;

    always_comb begin
        row_d = row_q;
        if (load) begin
            row_d = row_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign bit_out = row_q[sel_x];

endmodule

// File: rtl/maze_loader.sv
// -----------------------------------------------------------------------------
// maze_loader
// Writer side of the rat-maze map memory. Accepts maze rows from a
// valid/ready stream, writes them one cell per cycle into the 1-bit-per-cell
// map memory, issues the start/~start pair to the solver, then leaves the
// memory bus to the solver until it reports done or fail and latches that
// result.
//
// Optional feature: define MAZE_CHECK_EN to add a one-cycle CHECK state after
// the final write. If the entry cell (0,0) or exit cell (N-1,N-1) is a wall the
// loader reports fail immediately without starting the solver.
//
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   in_valid/in_row     : row stream input (bit x = cell (x, current row))
//   in_ready            : loader accepts a row this cycle
//   cen, WR             : memory enable / write strobe (loader cycles only)
//   mem_x, mem_y        : cell address
//   mem_din             : cell value written
//   start               : solver start handshake
//   solver_done/fail    : solver result levels (sampled in SOLVE only)
//   busy                : load or solve in progress
//   res_valid, res_fail : latched result, held until the next accepted row
// -----------------------------------------------------------------------------
module maze_loader
    import maze_pkg::*;
#(
    parameter int N       = MAZE_N,
    parameter int COORD_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [N-1:0]       in_row,
    output logic               in_ready,
    output logic               cen,
    output logic               WR,
    output logic [COORD_W-1:0] mem_x,
    output logic [COORD_W-1:0] mem_y,
    output logic               mem_din,
    output logic               start,
    input  logic               solver_done,
    input  logic               solver_fail,
    output logic               busy,
    output logic               res_valid,
    output logic               res_fail
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(N - 1);

    loader_state_t      state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               res_valid_q, res_valid_d;
    logic               res_fail_q, res_fail_d;
    logic               row_load;
    logic               cell_bit;

`ifdef MAZE_CHECK_EN
    logic               corner_first_q, corner_first_d;
    logic               corner_last_q, corner_last_d;
`endif

    maze_row_shifter #(
        .N       (N),
        .COORD_W (COORD_W)
    ) u_row (
        .clk     (clk),
        .rst     (rst),
        .load    (row_load),
        .row_in  (in_row),
        .sel_x   (x_q),
        .bit_out (cell_bit)
    );

    // Next-state and output logic. Outputs are decoded from the current state,
    // so a reset returns every strobe to 0 in the following cycle.
    // Counters never wrap: each sweep ends on the x==N-1 / y==N-1 compares and
    // the counters are re-zeroed by the next row handshake.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        res_valid_d = res_valid_q;
        res_fail_d  = res_fail_q;
        row_load    = 1'b0;
        in_ready    = 1'b0;
        cen         = 1'b0;
        WR          = 1'b0;
        mem_x       = '0;
        mem_y       = '0;
        mem_din     = 1'b0;
        start       = 1'b0;
        busy        = 1'b1;
`ifdef MAZE_CHECK_EN
        corner_first_d = corner_first_q;
        corner_last_d  = corner_last_q;
`endif

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    row_load    = 1'b1;
                    x_d         = '0;
                    y_d         = '0;
                    res_valid_d = 1'b0;
                    state_d     = WRITE;
                end
            end

            WRITE: begin
                cen     = 1'b1;
                WR      = 1'b1;
                mem_x   = x_q;
                mem_y   = y_q;
                mem_din = cell_bit;
`ifdef MAZE_CHECK_EN
                if (x_q == '0 && y_q == '0) begin
                    corner_first_d = cell_bit;
                end
                if (x_q == LAST && y_q == LAST) begin
                    corner_last_d = cell_bit;
                end
`endif
                if (x_q == LAST) begin
                    if (y_q == LAST) begin
`ifdef MAZE_CHECK_EN
                        state_d = CHECK;
`else
                        state_d = START;
`endif
                    end else begin
                        state_d = ACCEPT;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end

            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    row_load = 1'b1;
                    y_d      = y_q + 1'b1;
                    x_d      = '0;
                    state_d  = WRITE;
                end
            end

            START: begin
                start   = 1'b1;
                state_d = RELEASE;
            end

            // start held low for one cycle so the solver sees start then ~start
            RELEASE: begin
                state_d = SOLVE;
            end

            // Memory bus left to the solver; fail has priority over done.
            SOLVE: begin
                if (solver_fail) begin
                    res_valid_d = 1'b1;
                    res_fail_d  = 1'b1;
                    state_d     = IDLE;
                end else if (solver_done) begin
                    res_valid_d = 1'b1;
                    res_fail_d  = 1'b0;
                    state_d     = IDLE;
                end
            end

            CHECK: begin
`ifdef MAZE_CHECK_EN
                // A walled entry or exit cannot be solved, so skip the solver.
                if (corner_first_q == WALL || corner_last_q == WALL) begin
                    res_valid_d = 1'b1;
                    res_fail_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = START;
                end
`else
                state_d = IDLE;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and result registers. A reset mid-write simply abandons
    // the sweep; whatever was already written stays in memory.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            res_valid_q <= 1'b0;
            res_fail_q  <= 1'b0;
`ifdef MAZE_CHECK_EN
            corner_first_q <= 1'b0;
            corner_last_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_valid_q <= res_valid_d;
            res_fail_q  <= res_fail_d;
`ifdef MAZE_CHECK_EN
            corner_first_q <= corner_first_d;
            corner_last_q  <= corner_last_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_fail  = res_fail_q;

endmodule
